sm_to_fp_encoder: RTL and testbench
===================================

# sm_to_fp_encoder

Sequential encoder that takes an 11-bit sign-magnitude value (sign `s`, magnitude `m[10:0]`) from the two's-complement-to-sign-magnitude stage and produces the 8-bit floating-point code {S, E[2:0], F[3:0]}, where value = F × 2^E. It sits directly downstream of that converter, ahead of the display/output logic.
- Normalisation is iterative: one left shift per cycle.
- Rounding is round-half-up on the first discarded bit, with saturation at the top code.
- Valid/ready handshakes are used on both sides.

## Interface
- Parameters: none; widths are fixed by the 8-bit output format.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents `s`/`m`.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `s`  in  1  sign of the input value.
- `m`  in  11  magnitude of the input value (0..2047).
- `out_valid`  out  1  result registers hold a valid code.
- `out_ready`  in  1  downstream consumes the result.
- `out_s`  out  1  result sign (registered copy of `s`).
- `out_e`  out  3  result exponent.
- `out_f`  out  4  result significand.

## Operation
- States and transitions:
  - IDLE: `in_ready`=1. On `in_valid`: latch `r`←`m`, `sg`←`s`, `e`←7, then go to NORM.
  - NORM: if `r[10]`=1 or `e`=0, go to ROUND. Otherwise `r`←`r`<<1 and `e`←`e`−1, and stay in NORM.
  - ROUND: compute the result and register it into `out_*`, set `out_valid`, then go to OUT.
  - OUT: hold the result until `out_ready`=1, then clear `out_valid` and go to IDLE.
- ROUND arithmetic:
  - Base significand: `f0`=`r[10:7]`. Round bit: `rb`=`r[6]`.
  - The 5-bit sum `f0`+`rb` has three outcomes:
    - Sum ≤ 15: F = sum, E = `e`.
    - Sum = 16 and `e`<7: F = 4'b1000, E = `e`+1.
    - Sum = 16 and `e`=7: saturate to F = 4'b1111, E = 3'd7.
- Exponent mapping: E = 7 − min(lz, 7), where lz is the count of leading zeros of `m`.
- Small values: when E reaches 0 with `r[10]`=0, `r[10:7]` equals the original `m[3:0]` and `r[6]`=0, so no round-up occurs.
- Zero: `m`=0 produces E=0, F=0. `out_s` still follows `s`.
- Sign handling: `s` is carried through unchanged and has no effect on E/F.
- `in_valid` is ignored outside IDLE. Upstream must hold `s`/`m` stable only in the accepting cycle.

## Timing
- Reset:
  - `rst`=1 at an edge forces IDLE and clears `out_valid`, `out_s`, `out_e` and `out_f` to 0.
  - `in_ready` reads 1 after reset.
  - A reset in any state, including mid-NORM or OUT with a pending result, abandons the operation and drops the result.
- Latency: an accept at edge T gives `out_valid`=1 after edge T+k+2, where k=min(lz,7). Range is 2..9 cycles.
- Throughput:
  - `out_ready` already high in OUT: `out_valid` stays high exactly one cycle, and IDLE (`in_ready`=1) follows on the next cycle.
  - Minimum issue interval is k+4 cycles.
- Hold rule: `out_*` are stable while `out_valid`=1 and `out_ready`=0.
- The handshake is registered. There is no combinational path from `in_valid` to `out_valid` or from `out_ready` to `in_ready`.

## Structure
- Shared package/header:
  - State encoding (IDLE, NORM, ROUND, OUT).
  - Constants `EXP_MAX`=3'd7, `F_SAT`=4'b1111, `F_WRAP`=4'b1000.
  - Field widths (M_W=11, E_W=3, F_W=4).
- One natural sub-module, `fp_round`: combinational (`r[10:7]`, `r[6]`, `e`) → (E, F), holding the carry/saturate logic. It is reused by a later single-cycle variant.
- FSM, shift register and handshake live in the top module.

## Test plan
- `s`=0, `m`=422 → `out_valid` 4 cycles after accept, `out_s`/`out_e`/`out_f`=0/5/13 (code 8'h5D).
- `s`=0, `m`=46 → round-up: F 1011→1100, E=2, code 8'h2C, latency 7.
- `s`=0, `m`=125 → significand carry: F=1000, E=4, code 8'h48.
- Saturation and extremes:
  - `s`=1, `m`=11'h7FF (from input −2048) → saturate to 8'hFF, latency 2.
  - `m`=0 → 8'h00, latency 9.
  - `m`=1 → 8'h01.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles → `out_*` stable and `in_ready`=0; release → one-cycle consume, then IDLE.
  - Assert `rst` mid-NORM → next cycle shows IDLE, `out_valid`=0, all outputs 0.

Source files
------------

// File: rtl/sm_to_fp_encoder_pkg.sv
// rtl/sm_to_fp_encoder_pkg.sv - shared types and constants for the sign-magnitude to float encoder
//
// Purpose: state encoding, field widths and special codes shared by the
//          encoder top and its rounding sub-module.
// Ports:   none (package).
package sm_to_fp_encoder_pkg;

  localparam int M_W = 11;  // magnitude width
  localparam int E_W = 3;   // exponent width
  localparam int F_W = 4;   // significand width

  localparam logic [E_W-1:0] EXP_MAX = 3'd7;
  localparam logic [F_W-1:0] F_SAT   = 4'b1111;  // top code significand
  localparam logic [F_W-1:0] F_WRAP  = 4'b1000;  // significand after a carry out

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/sm_to_fp_encoder_fp_round.sv
// rtl/sm_to_fp_encoder_fp_round.sv - combinational round-half-up with carry and saturation
//
// Purpose: given the normalised top nibble, the first discarded bit and the
//          current exponent, produce the final exponent and significand.
// Ports:
//   i_f0  in  4  base significand (normalised r[10:7])
//   i_rb  in  1  round bit (normalised r[6])
//   i_e   in  3  exponent after normalisation
//   o_e   out 3  rounded exponent
//   o_f   out 4  rounded significand
module fp_round
  import sm_to_fp_encoder_pkg::*;
(
  input  logic [F_W-1:0] i_f0,
  input  logic           i_rb,
  input  logic [E_W-1:0] i_e,
  output logic [E_W-1:0] o_e,
  output logic [F_W-1:0] o_f
);

  logic [F_W:0] w_sum;

  assign w_sum = {1'b0, i_f0} + {{F_W{1'b0}}, i_rb};

  always_comb begin
    o_e = i_e;
    o_f = w_sum[F_W-1:0];
    // A carry out of the nibble renormalises by one position; at the
    // largest exponent there is no room, so clamp to the top code instead.
    if (w_sum[F_W]) begin
      if (i_e == EXP_MAX) begin
        o_e = EXP_MAX;
        o_f = F_SAT;
      end else begin
        o_e = i_e + 3'd1;
        o_f = F_WRAP;
      end
    end
  end

endmodule

// File: rtl/sm_to_fp_encoder.sv
// rtl/sm_to_fp_encoder.sv - iterative sign-magnitude to 8-bit float encoder
//
// Purpose: accepts an 11-bit sign-magnitude value and produces the code
//          {S, E[2:0], F[3:0]} with value F * 2^E. Normalisation shifts one
//          bit per cycle, rounding is half-up with saturation at the top code.
// Ports:
//   clk        in  1   system clock, rising edge
//   rst        in  1   synchronous active-high reset
//   in_valid   in  1   upstream presents s/m
//   in_ready   out 1   high only while idle
//   s          in  1   input sign
//   m          in  11  input magnitude
//   out_valid  out 1   out_* hold a valid code
//   out_ready  in  1   downstream consumes the result
//   out_s      out 1   result sign
//   out_e      out 3   result exponent
//   out_f      out 4   result significand
module sm_to_fp_encoder
  import sm_to_fp_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           s,
  input  logic [M_W-1:0] m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_s,
  output logic [E_W-1:0] out_e,
  output logic [F_W-1:0] out_f
);

  state_t         r_state;
  logic [M_W-1:0] r_r;
  logic [E_W-1:0] r_e;
  logic           r_sg;
  logic           r_in_ready;

  logic [E_W-1:0] w_e;
  logic [F_W-1:0] w_f;

  assign in_ready = r_in_ready;

  fp_round u_fp_round (
    .i_f0 (r_r[M_W-1:M_W-F_W]),
    .i_rb (r_r[M_W-F_W-1]),
    .i_e  (r_e),
    .o_e  (w_e),
    .o_f  (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_r        <= '0;
      r_e        <= '0;
      r_sg       <= 1'b0;
      out_valid  <= 1'b0;
      out_s      <= 1'b0;
      out_e      <= '0;
      out_f      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_r        <= m;
            r_sg       <= s;
            r_e        <= EXP_MAX;
            r_in_ready <= 1'b0;
            r_state    <= ST_NORM;
          end
        end
        ST_NORM: begin
          // Stop once the leading one reaches the top, or when the exponent
          // bottoms out; small values then keep m[3:0] in r[10:7] unrounded.
          if (r_r[M_W-1] || (r_e == '0)) begin
            r_state <= ST_ROUND;
          end else begin
            r_r <= r_r << 1;
            r_e <= r_e - 3'd1;
          end
        end
        ST_ROUND: begin
          out_s     <= r_sg;
          out_e     <= w_e;
          out_f     <= w_f;
          out_valid <= 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_to_fp_encoder.sv
// tb/tb_sm_to_fp_encoder.sv - self-checking bench for sm_to_fp_encoder
module tb_sm_to_fp_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [10:0] m;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm_to_fp_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f)
  );

  // Reference: value ~= F * 2^E with F a 4-bit significand. E is the
  // smallest exponent making m / 2^E fit in 4 bits; F is m / 2^E rounded
  // half-up; an overflow to 16 renormalises or saturates.
  function automatic int ref_exp0(input int mv);
    int bl;
    bl = 0;
    for (int i = 0; i < 11; i++) if (((mv >> i) & 1) == 1) bl = i + 1;
    return (bl <= 4) ? 0 : bl - 4;
  endfunction

  function automatic logic [7:0] ref_code(input bit sv, input int mv);
    int e, f;
    e = ref_exp0(mv);
    f = (e == 0) ? mv : (mv + (1 << (e - 1))) >> e;
    if (f == 16) begin
      if (e == 7) f = 15;
      else begin e = e + 1; f = 8; end
    end
    return {sv, e[2:0], f[3:0]};
  endfunction

  function automatic int ref_lat(input int mv);
    return 2 + (7 - ref_exp0(mv));
  endfunction

  task automatic issue(input bit is, input logic [10:0] im, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    s = is;
    m = im;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    s = $urandom_range(0, 1);
    m = 11'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    checks++;
    if ({out_s, out_e, out_f} !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: code=%h, required 00", {out_s, out_e, out_f});
    end
  endtask

  task automatic test_directed;
    logic [19:0] tbl [7];
    bit ok;
    int lat;
    logic [7:0] exp_code;
    // {s, m[10:0], code[7:0]}
    tbl[0] = {1'b0, 11'd422,   8'h5D};
    tbl[1] = {1'b0, 11'd46,    8'h2C};
    tbl[2] = {1'b0, 11'd125,   8'h48};
    tbl[3] = {1'b1, 11'h7FF,   8'hFF};
    tbl[4] = {1'b0, 11'd0,     8'h00};
    tbl[5] = {1'b0, 11'd1,     8'h01};
    tbl[6] = {1'b1, 11'd0,     8'h80};
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      int exp_lat;
      exp_lat = (t == 0) ? 4 : (t == 1) ? 7 : (t == 2) ? 6 : (t == 3) ? 2 : 9;
      exp_code = tbl[t][7:0];
      issue(tbl[t][19], tbl[t][18:8], ok);
      wait_out(lat, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir_timeout[%0d]: out_valid never rose, required latency %0d", t, exp_lat);
        continue;
      end
      if ({out_s, out_e, out_f} !== exp_code) begin
        errors++;
        $display("FAIL dir_code[%0d]: code=%h, required %h", t, {out_s, out_e, out_f}, exp_code);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL dir_lat[%0d]: latency=%0d, required %0d", t, lat, exp_lat);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_consume[%0d]: out_valid=%b in_ready=%b, required 0/1", t, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int lat;
    bit rs;
    int rm;
    out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      rs = 1'($urandom_range(0, 1));
      rm = int'($urandom_range(0, 2047)) >> $urandom_range(0, 10);
      issue(rs, rm[10:0], ok);
      wait_out(lat, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd_timeout: m=%0d never produced out_valid", rm);
        continue;
      end
      if ({out_s, out_e, out_f} !== ref_code(rs, rm)) begin
        errors++;
        $display("FAIL rnd_code: s=%0d m=%0d code=%h, required %h", rs, rm, {out_s, out_e, out_f}, ref_code(rs, rm));
      end
      checks++;
      if (lat != ref_lat(rm)) begin
        errors++;
        $display("FAIL rnd_lat: m=%0d latency=%0d, required %0d", rm, lat, ref_lat(rm));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int lat;
    int first;
    int mv [3];
    mv[0] = 11'h7FF; mv[1] = 422; mv[2] = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      issue(1'b0, mv[t][10:0], ok);
      first = acc_cyc;
      issue(1'b0, mv[t][10:0], ok);
      checks++;
      if (!ok || (acc_cyc - first) != ref_lat(mv[t]) + 2) begin
        errors++;
        $display("FAIL b2b_interval: m=%0d interval=%0d, required %0d", mv[t], acc_cyc - first, ref_lat(mv[t]) + 2);
      end
      wait_out(lat, ok);
      checks++;
      if (!ok || {out_s, out_e, out_f} !== ref_code(1'b0, mv[t])) begin
        errors++;
        $display("FAIL b2b_code: m=%0d code=%h, required %h", mv[t], {out_s, out_e, out_f}, ref_code(1'b0, mv[t]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int lat;
    out_ready = 1'b0;
    issue(1'b0, 11'd422, ok);
    wait_out(lat, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_s, out_e, out_f} !== 8'h5D) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b code=%h, required 1/0/5d", i, out_valid, in_ready, {out_s, out_e, out_f});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    int lat;
    out_ready = 1'b1;
    issue(1'b1, 11'h7FF, ok);
    wait_out(lat, ok);
    @(negedge clk);
    issue(1'b0, 11'd1, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_s, out_e, out_f} !== 8'h00) begin
      errors++;
      $display("FAIL rst_norm: in_ready=%b valid=%b code=%h, required 1/0/00", in_ready, out_valid, {out_s, out_e, out_f});
    end
    wait_out(lat, ok);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL rst_abandon: out_valid rose after %0d cycles, required never", lat);
    end
    out_ready = 1'b0;
    issue(1'b0, 11'd125, ok);
    wait_out(lat, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_s, out_e, out_f} !== 8'h00) begin
      errors++;
      $display("FAIL rst_out: in_ready=%b valid=%b code=%h, required 1/0/00", in_ready, out_valid, {out_s, out_e, out_f});
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    s = 1'b0;
    m = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
